ras_ctrl: RTL

- Sequencing controller in front of the return-address stack (RAS).
- Accepts call/return hints from fetch and commit/mispredict events from the backend.
- Turns them into correctly ordered single-cycle push/pop/commit/flush strobes for the RAS.
- Throttles fetch so uncommitted speculative RAS actions never exceed the RAS pending-action capacity.
- Sits between the branch predictor front end and one RAS instance.

---
 rtl/ras_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ras_ctrl.sv
// Return-address-stack sequencer: fetch hints and backend commit/flush events become single-cycle RAS strobes one cycle later.
// fe_ready throttles fetch at MAX_INFLIGHT uncommitted actions; RAS_CTRL_STATS_EN adds flush/stall counters.
module ras_ctrl #(
  parameter int WIDTH        = 32,
  parameter int MAX_INFLIGHT = 16,
  parameter int INIT_CYCLES  = 2,
  parameter int FLUSH_STALL  = 2
) (
  input  logic                          clk,
  input  logic                          rst_ni,
  input  logic                          fe_valid,
  input  logic                          fe_call,
  input  logic                          fe_ret,
  input  logic [WIDTH-1:0]              fe_addr,
  output logic                          fe_ready,
  input  logic                          cm_valid,
  input  logic                          cm_call,
  input  logic                          cm_ret,
  input  logic                          mp_flush,
  output logic                          ras_push,
  output logic                          ras_pop,
  output logic                          ras_commit_push,
  output logic                          ras_commit_pop,
  output logic                          ras_flush,
  output logic [WIDTH-1:0]              ras_din,
  output logic [$clog2(MAX_INFLIGHT):0] inflight,
  output logic                          err_underflow
`ifdef RAS_CTRL_STATS_EN
  ,
  output logic [15:0]                   stat_flushes,
  output logic [15:0]                   stat_stalls
`endif
);

  localparam int CW   = $clog2(MAX_INFLIGHT) + 1;
  localparam int TMAX = (INIT_CYCLES > FLUSH_STALL) ? INIT_CYCLES : FLUSH_STALL;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_INFLIGHT);
  localparam logic [TW-1:0] INIT_LAST  = TW'(INIT_CYCLES - 1);
  localparam logic [TW-1:0] STALL_LAST = TW'(FLUSH_STALL - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_RUN,
    S_FLUSH_PEND,
    S_FLUSH,
    S_RECOVER
  } state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              push_q, push_d;
  logic              pop_q, pop_d;
  logic              cpush_q, cpush_d;
  logic              cpop_q, cpop_d;
  logic              flush_q, flush_d;
  logic [WIDTH-1:0]  din_q, din_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic              err_q, err_d;

  logic              fe_acc;
  logic              cm_live;
  logic              cm_acc;
  logic              cm_under;
  logic              cm_dec;

  assign fe_ready = (state_q == S_RUN) && (inflight_q < MAX_CNT) && !mp_flush;
  assign fe_acc   = fe_valid && fe_ready && (fe_call || fe_ret);
  assign cm_live  = (state_q != S_INIT);
  assign cm_acc   = cm_live && cm_valid && (cm_call || cm_ret);
  assign cm_under = cm_acc && (inflight_q == '0);
  assign cm_dec   = cm_acc && !cm_under;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    flush_d = 1'b0;
    case (state_q)
      S_INIT: begin
        if (tmr_q == INIT_LAST) begin
          state_d = S_RUN;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_RUN: begin
        if (mp_flush) state_d = S_FLUSH_PEND;
      end
      // One cycle of slack lets commits from the flush cycle reach the RAS before it rewinds.
      S_FLUSH_PEND: begin
        state_d = S_FLUSH;
        flush_d = 1'b1;
      end
      S_FLUSH: begin
        state_d = S_RECOVER;
        tmr_d   = '0;
      end
      S_RECOVER: begin
        if (mp_flush) begin
          state_d = S_FLUSH_PEND;
        end else if (tmr_q == STALL_LAST) begin
          state_d = S_RUN;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: begin
        state_d = S_INIT;
        tmr_d   = '0;
      end
    endcase
  end

  always_comb begin
    push_d  = fe_acc && fe_call;
    pop_d   = fe_acc && fe_ret;
    din_d   = fe_acc ? fe_addr : din_q;
    cpush_d = cm_live && cm_valid && cm_call;
    cpop_d  = cm_live && cm_valid && cm_ret;
    err_d   = err_q || cm_under;

    case ({fe_acc, cm_dec})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
    // The RAS drops every speculative entry on flush, so the count restarts from zero.
    if (state_q == S_FLUSH_PEND) inflight_d = '0;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_INIT;
      tmr_q      <= '0;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      cpush_q    <= 1'b0;
      cpop_q     <= 1'b0;
      flush_q    <= 1'b0;
      din_q      <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      push_q     <= push_d;
      pop_q      <= pop_d;
      cpush_q    <= cpush_d;
      cpop_q     <= cpop_d;
      flush_q    <= flush_d;
      din_q      <= din_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign ras_push        = push_q;
  assign ras_pop         = pop_q;
  assign ras_commit_push = cpush_q;
  assign ras_commit_pop  = cpop_q;
  assign ras_flush       = flush_q;
  assign ras_din         = din_q;
  assign inflight        = inflight_q;
  assign err_underflow   = err_q;

`ifdef RAS_CTRL_STATS_EN
  logic [15:0] stat_flushes_q, stat_flushes_d;
  logic [15:0] stat_stalls_q, stat_stalls_d;

  always_comb begin
    stat_flushes_d = stat_flushes_q;
    stat_stalls_d  = stat_stalls_q;
    if (flush_d && (stat_flushes_q != 16'hFFFF)) stat_flushes_d = stat_flushes_q + 16'd1;
    if ((state_q == S_RUN) && fe_valid && !fe_ready && (stat_stalls_q != 16'hFFFF))
      stat_stalls_d = stat_stalls_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_flushes_q <= '0;
      stat_stalls_q  <= '0;
    end else begin
      stat_flushes_q <= stat_flushes_d;
      stat_stalls_q  <= stat_stalls_d;
    end
  end

  assign stat_flushes = stat_flushes_q;
  assign stat_stalls  = stat_stalls_q;
`endif

endmodule
